// File: rtl/dpram_stream_reader_pkg.sv
// Shared definitions for the dual-port RAM port-B stream reader:
// FSM state encoding and default widths.
package dpram_stream_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dpram_stream_reader_fifo.sv
// Small synchronous FIFO that absorbs RAM read returns under backpressure.
// Head word is taken straight from storage registers and forced to zero when empty.
module dpram_stream_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // storage is data only; emptiness is tracked by the reset count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/dpram_stream_reader.sv
// Reads LEN consecutive words from RAM port B starting at BASE and streams them
// out on valid/ready; read issue is credit-limited so the FIFO never overflows.
module dpram_stream_reader
  import dpram_stream_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_dat,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [ADDR_W:0]   r_remaining;
  logic              r_inflight;
  logic              w_issue;
  logic              w_credit;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_used;

  // registered count only: a same-cycle pop does not release a credit
  assign w_used   = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
  assign w_credit = (w_used < (CNT_W + 1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (length == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        w_issue = w_credit;
        if (w_credit && r_remaining == (ADDR_W + 1)'(1)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_inflight && w_empty) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight  <= 1'b0;
      r_addr_hold <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_addr_hold <= r_addr;
    end
  end

  // run address and word count are loaded before use, so they carry no reset
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start) begin
      r_addr      <= base_addr;
      r_remaining <= length;
    end else if (w_issue) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - (ADDR_W + 1)'(1);
    end
  end

  assign mem_rd    = w_issue;
  assign mem_addr  = w_issue ? r_addr : r_addr_hold;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  dpram_stream_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_wdata (mem_dat),
    .i_pop   (w_pop),
    .o_rdata (out_dat),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(r_inflight && w_full));

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Randomized bench for dpram_stream_reader against a word-queue / credit-count model.
module tb_dpram_stream_reader;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_dat;
  logic [15:0] out_dat;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] ram [256];
  int n_checks;
  int n_errors;

  dpram_stream_reader #(
    .ADDR_W     (8),
    .DATA_W     (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_dat   (mem_dat),
    .out_dat   (out_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port B: one-cycle read latency, junk on the bus when not reading
  always @(posedge clk) begin
    if (mem_rd) mem_dat <= ram[mem_addr];
    else        mem_dat <= 16'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int c);
    if (mode == 1) return (c % 4 == 1) || (c % 4 == 0);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic check_idle_zero(input string tag);
    @(negedge clk);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    chk({tag, "_mem_rd"},    32'(mem_rd),    32'h0);
    chk({tag, "_out_dat"},   32'(out_dat),   32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_done"},      32'(done),      32'h0);
  endtask

  // Called just after a rising edge with the DUT idle.
  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_stream(input logic [7:0] base, input logic [8:0] len, input int mode, input bit poke);
    logic [15:0] expq [$];
    logic [15:0] prev_dat;
    logic [15:0] w;
    int issued, mcount, cyc, budget;
    bit inflight_m, prev_stall, done_seen, exp_done, drain_hit, rd, xfer;

    for (int i = 0; i < int'(len); i++) expq.push_back(ram[(int'(base) + i) % 256]);
    issued = 0; mcount = 0; cyc = 0; budget = int'(len) * 4 + 20;
    inflight_m = 0; prev_stall = 0; done_seen = 0; exp_done = 0; drain_hit = 0;
    prev_dat = '0;

    base_addr = base;
    length    = len;
    start     = 1'b1;
    out_ready = ready_pat(mode, 1);
    @(posedge clk); #1;
    start = 1'b0;

    while (!done_seen && cyc < budget) begin
      cyc++;
      @(negedge clk);
      exp_done = (len == 0) ? (cyc == 1) : drain_hit;
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(len != 0 && !exp_done));
      if (mode == 0) begin
        chk("done_latency",  32'(done),      32'(cyc == ((len == 0) ? 1 : int'(len) + 4)));
        chk("valid_latency", 32'(out_valid), 32'(cyc >= 3 && cyc <= int'(len) + 2));
      end
      chk("out_valid", 32'(out_valid), 32'(mcount > 0));
      rd = (issued < int'(len)) && (mcount + int'(inflight_m) < DEPTH);
      chk("mem_rd", 32'(mem_rd), 32'(rd));
      drain_hit = (len != 0) && (issued == int'(len)) && !inflight_m && (mcount == 0) && !exp_done;
      if (mem_rd) begin
        chk("mem_addr", 32'(mem_addr), 32'((int'(base) + issued) % 256));
        issued++;
      end
      if (prev_stall) chk("stall_dat", 32'(out_dat), 32'(prev_dat));
      xfer = out_valid && out_ready;
      if (xfer) begin
        if (expq.size() == 0) chk("extra_word", 32'(out_dat), 32'hDEAD_0000);
        else begin
          w = expq.pop_front();
          chk("out_dat", 32'(out_dat), 32'(w));
        end
      end
      mcount     = mcount + int'(inflight_m) - int'(xfer);
      inflight_m = mem_rd;
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_dat;
      if (done) done_seen = 1'b1;
      @(posedge clk); #1;
      out_ready = ready_pat(mode, cyc + 1);
      start     = poke && (cyc + 1 == 2);
      if (start) begin
        base_addr = ~base;
        length    = 9'd5;
      end
    end
    if (!done_seen) chk("timeout_done", 32'h0, 32'h1);
    chk("words_left", 32'(expq.size()), 32'h0);
    chk("issued",     32'(issued),      32'(len));
    @(negedge clk);
    chk("post_busy",   32'(busy),   32'h0);
    chk("post_done",   32'(done),   32'h0);
    chk("post_mem_rd", 32'(mem_rd), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) ram[16 + i] = 16'(16'hA0 + i);

    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_stream(8'h10, 9'd4, 0, 1'b0);
    run_stream(8'hFE, 9'd4, 0, 1'b0);
    run_stream(8'($urandom), 9'd8, 1, 1'b0);
    run_stream(8'($urandom), 9'd0, 0, 1'b0);
    run_stream(8'($urandom), 9'd0, 2, 1'b0);
    run_stream(8'($urandom), 9'd6, 0, 1'b1);

    // abort a 16-word run two cycles in
    base_addr = 8'($urandom);
    length    = 9'd16;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("abort");
    @(posedge clk); #1;
    run_stream(8'h80, 9'd2, 0, 1'b0);

    run_stream(8'h55, 9'd256, 0, 1'b0);
    for (int k = 0; k < 6; k++) run_stream(8'($urandom), 9'($urandom_range(1, 20)), 2, 1'b0);
    run_stream(8'($urandom), 9'($urandom_range(1, 12)), 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpram_stream_reader.md
Name: dpram_stream_reader

Overview:
- Downstream consumer of the second (B) port of the dual-port RAM behind peripheral_RAM.
- On a start pulse it reads a programmable run of consecutive 16-bit words from port B: start address BASE, count LEN.
- Presents the words on a valid/ready stream to the next stage (serializer/transmitter).
- Owns the port-B read address; hides the RAM's 1-cycle read latency behind a small FIFO so backpressure never loses data.

Parameters:
- ADDR_W, 8, RAM port-B address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, word width.
- FIFO_DEPTH, 4, output buffer entries; minimum 2; sustains 1 word/cycle when ≥3.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, sampled only in IDLE
- base_addr  in  ADDR_W  first RAM address, latched on accepted start
- length  in  ADDR_W+1  word count 0..2^ADDR_W, latched on accepted start
- mem_addr  out  ADDR_W  port-B read address
- mem_rd  out  1  port-B read enable
- mem_dat  in  DATA_W  port-B read data, valid the cycle after mem_rd
- out_dat  out  DATA_W  stream data (FIFO head)
- out_valid  out  1  stream valid
- out_ready  in  1  downstream ready; transfer when out_valid & out_ready
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset values: mem_addr=0, mem_rd=0, out_dat=0, out_valid=0, busy=0, done=0. FIFO emptied, in-flight flag cleared, state=IDLE.
- Reset mid-run aborts immediately; the returning mem_dat of an in-flight read is discarded; no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start & length≠0: latch addr←base_addr, remaining←length; go to RUN.
  - start & length=0: go to DONE; no reads issued.
  - start is ignored in every other state.
- RUN:
  - Issue rule: mem_rd=1 when fifo_count + inflight < FIFO_DEPTH.
  - fifo_count is the registered value; a pop in the same cycle does not free a credit.
  - On issue: mem_addr=addr, then addr←addr+1 mod 2^ADDR_W (0xFF→0x00), remaining←remaining−1.
  - When the issue with remaining=1 occurs, go to DRAIN.
- Read return: inflight is set in the cycle after mem_rd=1. mem_dat is written into the FIFO on the edge ending that cycle.
- DRAIN: when inflight=0 and FIFO empty, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start in cycle T → mem_rd in T+1 → first out_valid in T+3.
- Throughput: with out_ready held high, one word per cycle from T+3. The last word transfers at T+2+LEN and done pulses at T+4+LEN.
- FIFO:
  - Registered output; out_dat holds the head value while out_valid & !out_ready (stable under backpressure).
  - Simultaneous push and pop in one cycle keeps the count unchanged.
  - Overflow is impossible by the credit rule; an assertion flags a push while full.
- mem_rd stays low outside RUN; mem_addr holds its last value.
- length=2^ADDR_W (256) reads the whole RAM once, wrapping from base_addr back to base_addr−1.

Decomposition:
- Shared package dpram_stream_pkg holds:
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
  - default widths ADDR_W/DATA_W
- One sub-module: dpram_stream_fifo, a synchronous FIFO (DEPTH, DATA_W) with push, pop, count, empty, full and registered head output.

Test Plan:
- Basic run: preload RAM[0x10..0x13]=0xA0..0xA3; start with base=0x10, length=4, out_ready=1 → out_dat sequence A0,A1,A2,A3 on consecutive cycles from T+3; done pulses at T+8; busy low after.
- Wrap-around: base=0xFE, length=4 → mem_addr sequence FE,FF,00,01; words delivered in that order.
- Backpressure: length=8, out_ready toggled 1,0,0,1,… → no word lost or duplicated; out_dat stable while stalled; mem_rd never issued with count+inflight≥FIFO_DEPTH.
- Zero length and ignored start: length=0 → no mem_rd, done one cycle after start. A start pulse during RUN does not change the active run.
- Reset mid-run: assert rst two cycles into a length=16 run → next cycle all outputs 0. A fresh run with base=0x80, length=2 then delivers RAM[0x80],RAM[0x81] only.
- Full RAM: length=256, base=0x55, out_ready=1 → 256 words in address order 55..FF,00..54, one per cycle, single done pulse.
